// File: rtl/layer00_sched.sv
// ---------------------------------------------------------------------------
// layer00_sched
//
// Purpose:
//   Sequences one layer00 conv engine across a full output feature map.
//   The outer loop walks the filter groups. Each group has four filters, one
//   per engine output lane. The inner loop walks the passes of a group; each
//   pass is one start pulse to the engine.
//   For each group the scheduler presents that group's four biases from an
//   internal bias register file. It counts the engine's valid pulses and
//   packs the four 8-bit lanes into 32-bit output-buffer writes. Write
//   addresses are linear: group-major, then pass, then output.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_start             run request, accepted only in IDLE
//   i_abort             abort the run; the block is back in IDLE next cycle
//   i_cfg_we/_grp/_bias bias register file write port
//                       (writes are ignored while busy)
//   o_layer_start       one-cycle engine start pulse
//   o_bias0..3          biases of the current group, held for the whole pass
//   i_layer_vld, i_layer0..3   engine output beat
//   o_wr_en/_addr/_data output-buffer write beat
//   o_busy, o_done, o_err      run status (o_err is sticky until next start)
//   o_grp, o_pass       current group / pass index
//   o_dbg_state         current FSM state encoding, for observation only
//
// Handshake semantics:
//   There is no back-pressure anywhere. Each cycle in which i_layer_vld is
//   high carries one beat, and only beats that arrive in RUN are accepted.
//   Each accepted beat produces exactly one cycle of o_wr_en on the
//   following cycle. A beat that arrives in any other state is dropped and
//   sets o_err.
// ---------------------------------------------------------------------------
module layer00_sched #(
  parameter int NUM_GRP       = 4,
  parameter int NUM_PASS      = 16,
  parameter int OUTS_PER_PASS = 64,
  parameter int DRAIN         = 8,
  parameter int TIMEOUT       = 1024,
  parameter int AW            = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic                        i_cfg_we,
  input  logic [$clog2(NUM_GRP)-1:0]  i_cfg_grp,
  input  logic [63:0]                 i_cfg_bias,
  output logic                        o_layer_start,
  output logic [15:0]                 o_bias0,
  output logic [15:0]                 o_bias1,
  output logic [15:0]                 o_bias2,
  output logic [15:0]                 o_bias3,
  input  logic                        i_layer_vld,
  input  logic [7:0]                  i_layer0,
  input  logic [7:0]                  i_layer1,
  input  logic [7:0]                  i_layer2,
  input  logic [7:0]                  i_layer3,
  output logic                        o_wr_en,
  output logic [AW-1:0]               o_wr_addr,
  output logic [31:0]                 o_wr_data,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_err,
  output logic [$clog2(NUM_GRP)-1:0]  o_grp,
  output logic [$clog2(NUM_PASS)-1:0] o_pass,
  output logic [2:0]                  o_dbg_state
);

  localparam int GW = $clog2(NUM_GRP);
  localparam int PW = $clog2(NUM_PASS);
  localparam int VW = (OUTS_PER_PASS > 1) ? $clog2(OUTS_PER_PASS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t        r_state;
  logic [63:0]   r_bias_file [NUM_GRP];
  logic [63:0]   r_bias;
  logic [GW-1:0] r_grp;
  logic [PW-1:0] r_pass;
  logic [VW-1:0] r_vld_cnt;
  logic [TW-1:0] r_tmo;
  logic [DW-1:0] r_gap_cnt;
  logic [AW-1:0] r_addr;
  logic          r_layer_start;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [31:0]   r_wr_data;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic          w_abort;
  logic          w_vld_run;

  // An abort from IDLE has nothing to cancel, so it is ignored there.
  assign w_abort   = i_abort && (r_state != S_IDLE);
  assign w_vld_run = i_layer_vld && (r_state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      for (int g = 0; g < NUM_GRP; g++) begin
        r_bias_file[g] <= '0;
      end
      r_bias        <= '0;
      r_grp         <= '0;
      r_pass        <= '0;
      r_vld_cnt     <= '0;
      r_tmo         <= '0;
      r_gap_cnt     <= '0;
      r_addr        <= '0;
      r_layer_start <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_layer_start <= 1'b0;
      r_done        <= 1'b0;
      r_wr_en       <= 1'b0;

      // The bias file is frozen while a run is using it.
      if (i_cfg_we && !r_busy) begin
        r_bias_file[i_cfg_grp] <= i_cfg_bias;
      end

      // The write path does not depend on the FSM transition taken this
      // cycle. A beat that lands together with an abort is still written.
      if (w_vld_run) begin
        r_wr_en   <= 1'b1;
        r_wr_data <= {i_layer3, i_layer2, i_layer1, i_layer0};
        r_wr_addr <= r_addr;
        r_addr    <= r_addr + AW'(1);
      end

      if (w_abort) begin
        // Abort wins over every transition. Because the start pulse is
        // registered out of START, an abort in START also suppresses it.
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_state <= S_LOAD;
              r_grp   <= '0;
              r_pass  <= '0;
              r_addr  <= '0;
              r_err   <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
          S_LOAD: begin
            r_bias  <= r_bias_file[r_grp];
            r_state <= S_START;
          end
          S_START: begin
            r_layer_start <= 1'b1;
            r_vld_cnt     <= '0;
            r_tmo         <= '0;
            r_state       <= S_RUN;
          end
          S_RUN: begin
            if (i_layer_vld) begin
              r_tmo <= '0;
              if (r_vld_cnt == VW'(OUTS_PER_PASS - 1)) begin
                r_gap_cnt <= '0;
                r_state   <= S_GAP;
              end else begin
                r_vld_cnt <= r_vld_cnt + VW'(1);
              end
            end else if (r_tmo == TW'(TIMEOUT - 1)) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
          S_GAP: begin
            if (r_gap_cnt == DW'(DRAIN - 1)) begin
              r_gap_cnt <= '0;
              if (r_pass != PW'(NUM_PASS - 1)) begin
                r_pass  <= r_pass + PW'(1);
                r_state <= S_START;
              end else if (r_grp != GW'(NUM_GRP - 1)) begin
                r_grp   <= r_grp + GW'(1);
                r_pass  <= '0;
                r_state <= S_LOAD;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end
            end else begin
              r_gap_cnt <= r_gap_cnt + DW'(1);
            end
          end
          S_DONE:  r_state <= S_IDLE;
          S_ERR:   r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end

      // An engine beat outside RUN means the engine and the scheduler
      // disagree on the pass boundary. Flag it, but keep sequencing.
      if (i_layer_vld && (r_state != S_RUN)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_layer_start = r_layer_start;
  assign o_bias0       = r_bias[15:0];
  assign o_bias1       = r_bias[31:16];
  assign o_bias2       = r_bias[47:32];
  assign o_bias3       = r_bias[63:48];
  assign o_wr_en       = r_wr_en;
  assign o_wr_addr     = r_wr_addr;
  assign o_wr_data     = r_wr_data;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_grp         = r_grp;
  assign o_pass        = r_pass;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_layer00_sched.sv
// ---------------------------------------------------------------------------
// tb_layer00_sched
//
// Bench for layer00_sched with a small geometry: 4 groups, 2 passes per
// group and 4 outputs per pass.
//
// A behavioural engine answers each start pulse with random lanes and random
// spacing. For every beat it drives, it pushes the expected write
// {address, data}. When a run starts, the main process pushes one expected
// start record {bias, grp, pass} per pass. A monitor pops and compares both
// queues whenever the DUT presents a start pulse or a write.
// ---------------------------------------------------------------------------
module tb_layer00_sched;

  localparam int NUM_GRP    = 4;
  localparam int NUM_PASS   = 2;
  localparam int OPP        = 4;
  localparam int DRAIN      = 8;
  localparam int TIMEOUT    = 16;
  localparam int AW         = 16;
  localparam int GW         = $clog2(NUM_GRP);
  localparam int PW         = $clog2(NUM_PASS);
  localparam int TOTAL_PASS = NUM_GRP * NUM_PASS;
  localparam int RUN_WR     = TOTAL_PASS * OPP;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          i_start, i_abort, i_cfg_we, i_layer_vld;
  logic [GW-1:0] i_cfg_grp;
  logic [63:0]   i_cfg_bias;
  logic [7:0]    lane0, lane1, lane2, lane3;
  logic          o_layer_start, o_wr_en, o_busy, o_done, o_err;
  logic [15:0]   o_bias0, o_bias1, o_bias2, o_bias3;
  logic [AW-1:0] o_wr_addr;
  logic [31:0]   o_wr_data;
  logic [GW-1:0] o_grp;
  logic [PW-1:0] o_pass;
  logic [2:0]    o_dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  layer00_sched #(
    .NUM_GRP(NUM_GRP), .NUM_PASS(NUM_PASS), .OUTS_PER_PASS(OPP),
    .DRAIN(DRAIN), .TIMEOUT(TIMEOUT), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_cfg_we(i_cfg_we), .i_cfg_grp(i_cfg_grp), .i_cfg_bias(i_cfg_bias),
    .o_layer_start(o_layer_start),
    .o_bias0(o_bias0), .o_bias1(o_bias1), .o_bias2(o_bias2), .o_bias3(o_bias3),
    .i_layer_vld(i_layer_vld),
    .i_layer0(lane0), .i_layer1(lane1), .i_layer2(lane2), .i_layer3(lane3),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_grp(o_grp), .o_pass(o_pass), .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [AW+32-1:0]    exp_q[$];        // {addr, data}
  logic [64+GW+PW-1:0] exp_start_q[$];  // {bias, grp, pass}
  logic [63:0]         bias_model [NUM_GRP];
  logic [63:0]         cur_bias = '0;

  int done_cnt = 0, wr_seen = 0, starts_seen = 0;
  int done_base, wr_base, start_base;
  int run_id = 0;

  // test-mode flags (written by the main process only)
  bit stall_mode = 0, spur_gap = 0, abort_last = 0, kill = 0;
  int last_vld_cyc = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [64+GW+PW-1:0] ms;
  logic [AW+32-1:0]    mw;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_done) done_cnt++;
        if (o_layer_start) begin
          starts_seen++;
          if (exp_start_q.size() == 0) begin
            vec_cnt++; miss_cnt++;
            $display("FAIL start_unexpected: got start grp=%0d pass=%0d expected none",
                     o_grp, o_pass);
          end else begin
            ms = exp_start_q.pop_front();
            chk("start_bias", {o_bias3, o_bias2, o_bias1, o_bias0}, ms[64+GW+PW-1:GW+PW]);
            chk("start_grp_pass", {o_grp, o_pass}, ms[GW+PW-1:0]);
            cur_bias = ms[64+GW+PW-1:GW+PW];
          end
        end
        if (o_wr_en) begin
          wr_seen++;
          if (exp_q.size() == 0) begin
            vec_cnt++; miss_cnt++;
            $display("FAIL wr_unexpected: got addr=%0h data=%0h expected none",
                     o_wr_addr, o_wr_data);
          end else begin
            mw = exp_q.pop_front();
            chk("wr_addr", o_wr_addr, mw[AW+31:32]);
            chk("wr_data", o_wr_data, mw[31:0]);
            chk("wr_bias_stable", {o_bias3, o_bias2, o_bias1, o_bias0}, cur_bias);
          end
        end
      end
    end
  end

  // ---------------- behavioural engine ----------------
  int            eng_run = 0, eng_pass = 0, gap_n = 0;
  logic [AW-1:0] exp_addr = '0;
  initial begin : engine
    i_layer_vld = 1'b0; i_abort = 1'b0;
    lane0 = '0; lane1 = '0; lane2 = '0; lane3 = '0;
    forever begin
      @(negedge clk);
      if (o_layer_start && !rst) begin
        if (run_id != eng_run) begin
          eng_run = run_id; eng_pass = 0; exp_addr = '0;
        end
        for (int k = 0; k < OPP; k++) begin
          gap_n = $urandom_range(0, 2);
          repeat (gap_n) begin @(posedge clk); #1; i_layer_vld = 1'b0; end
          @(posedge clk); #1;
          if (kill || (stall_mode && eng_pass == 0 && k == 2)) begin
            i_layer_vld = 1'b0;
            break;
          end
          lane0 = 8'($urandom); lane1 = 8'($urandom);
          lane2 = 8'($urandom); lane3 = 8'($urandom);
          i_layer_vld = 1'b1;
          exp_q.push_back({exp_addr, lane3, lane2, lane1, lane0});
          exp_addr++;
          last_vld_cyc = cyc;
          if (abort_last && eng_pass == TOTAL_PASS - 1 && k == OPP - 1) i_abort = 1'b1;
        end
        @(posedge clk); #1;
        i_layer_vld = 1'b0;
        if (i_abort) begin
          i_abort = 1'b0;
          @(negedge clk);
          chk("abort_busy_next_cycle", o_busy, 0);
        end
        if (spur_gap && eng_pass == 0 && !kill) begin
          // one stray beat while the scheduler is draining
          @(posedge clk); #1; i_layer_vld = 1'b1;
          @(posedge clk); #1; i_layer_vld = 1'b0;
        end
        eng_pass++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input int g, input logic [63:0] v, input bit update_model);
    @(posedge clk); #1;
    i_cfg_we = 1'b1; i_cfg_grp = GW'(g); i_cfg_bias = v;
    @(posedge clk); #1;
    i_cfg_we = 1'b0;
    if (update_model) bias_model[g] = v;
  endtask

  task automatic start_run();
    for (int g = 0; g < NUM_GRP; g++)
      for (int p = 0; p < NUM_PASS; p++)
        exp_start_q.push_back({bias_model[g], GW'(g), PW'(p)});
    done_base = done_cnt; wr_base = wr_seen; start_base = starts_seen;
    run_id++;
    @(posedge clk); #1; i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", o_busy, 1);
    chk("err_cleared_by_start", o_err, 0);
  endtask

  task automatic finish_run(input int exp_done, input bit exp_err, input int exp_wr,
                            input int exp_starts, input string tag);
    int n = 0;
    while (o_busy && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_busy_drop"}, o_busy, 0);
    repeat (4) @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt - done_base, exp_done);
    chk({tag, "_err"}, o_err, exp_err);
    chk({tag, "_writes"}, wr_seen - wr_base, exp_wr);
    chk({tag, "_starts"}, starts_seen - start_base, exp_starts);
    chk({tag, "_exp_q_drained"}, exp_q.size(), 0);
    exp_q.delete();
    exp_start_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, o_layer_start, 0);
    chk({tag, "_bias"}, {o_bias3, o_bias2, o_bias1, o_bias0}, 0);
    chk({tag, "_wr"}, {o_wr_en, o_wr_addr, o_wr_data}, 0);
    chk({tag, "_status"}, {o_busy, o_done, o_err}, 0);
    chk({tag, "_grp_pass"}, {o_grp, o_pass}, 0);
    chk({tag, "_state_idle"}, o_dbg_state, 0);
  endtask

  // ---------------- main sequence ----------------
  int n;
  initial begin : main
    rst = 1'b1; i_start = 1'b0; i_cfg_we = 1'b0;
    i_cfg_grp = '0; i_cfg_bias = '0;
    for (int g = 0; g < NUM_GRP; g++) bias_model[g] = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // grp g = {4g+4, 4g+3, 4g+2, 4g+1}
    for (int g = 0; g < NUM_GRP; g++)
      cfg_write(g, {16'(4*g+4), 16'(4*g+3), 16'(4*g+2), 16'(4*g+1)}, 1'b1);

    // plain run
    start_run();
    finish_run(1, 0, RUN_WR, TOTAL_PASS, "run_basic");

    // bias write while busy must be ignored
    start_run();
    repeat (3) @(negedge clk);
    cfg_write(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    finish_run(1, 0, RUN_WR, TOTAL_PASS, "run_busy_cfg");

    // engine stalls after two beats of the first pass
    stall_mode = 1;
    start_run();
    n = 0;
    while (!o_err && n < 300) begin @(negedge clk); n++; end
    chk("tmo_err_set", o_err, 1);
    // beat sampled on edge c+1; the tmo counter hits TIMEOUT-1 at edge
    // c+1+TIMEOUT and ERR becomes visible right after that edge
    chk("tmo_latency", cyc - last_vld_cyc, TIMEOUT + 1);
    chk("tmo_busy_low", o_busy, 0);
    repeat (5) @(negedge clk);
    chk("tmo_err_sticky", o_err, 1);
    finish_run(0, 1, 2, 1, "run_timeout");
    stall_mode = 0;

    // stray beat during drain (start_run also checks o_err is cleared)
    spur_gap = 1;
    start_run();
    finish_run(1, 1, RUN_WR, TOTAL_PASS, "run_spurious");
    spur_gap = 0;

    // abort coincident with the very last beat
    abort_last = 1;
    start_run();
    finish_run(0, 0, RUN_WR, TOTAL_PASS, "run_abort_last");
    abort_last = 0;

    // random biases, plain run
    for (int g = 0; g < NUM_GRP; g++)
      cfg_write(g, {$urandom, $urandom}, 1'b1);
    start_run();
    finish_run(1, 0, RUN_WR, TOTAL_PASS, "run_random");

    // synchronous reset in the middle of a run
    start_run();
    n = 0;
    while ((wr_seen - wr_base) < 10 && n < 500) begin @(negedge clk); n++; end
    chk("mid_reset_reached_run", o_busy, 1);
    @(posedge clk); #2;
    kill = 1; rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset");
    repeat (6) @(negedge clk);
    exp_q.delete(); exp_start_q.delete();
    kill = 0;
    for (int g = 0; g < NUM_GRP; g++) bias_model[g] = '0;
    start_run();
    finish_run(1, 0, RUN_WR, TOTAL_PASS, "run_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  // hard stop in case a wait above never resolves
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
